seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the two-digit seven-segment driver. Monitors a time-multiplexed, active-low seven-segment bus (shared segment lines plus per-digit selects), decodes each pattern back to a BCD digit, and filters glitches by requiring consecutive identical samples before committing. Sits between the display pins (or a display model) and self-check or readback logic.

## Interface
- STABLE_CNT, 8, consecutive identical valid samples of a digit required to commit it (≥2)
- iCLK  in  1  system clock, rising-edge
- iRST  in  1  reset, asynchronous, active-high
- iSEG  in  7  segment lines, active-low; bit0=a … bit6=g
- iDIG_SEL  in  2  digit selects, active-high; bit0 = ones digit, bit1 = tens digit
- iCLR_ERR  in  1  clears oERR_STICKY
- oD1  out  4  committed ones digit: 0–9, or 4'hF = blank
- oD2  out  4  committed tens digit: 0–9, or 4'hF = blank
- oVALID  out  1  high once both digits have committed at least once since reset
- oUPDATE  out  1  one-cycle pulse when oD1 or oD2 changes value
- oERR  out  1  one-cycle pulse: invalid pattern or select collision sampled
- oERR_STICKY  out  1  set by any oERR, cleared by iCLR_ERR

## Operation
- Sample qualification, every rising edge: iDIG_SEL == 2'b01 → sample for digit 1; 2'b10 → digit 2; 2'b00 → no sample; 2'b11 → collision (no sample, oERR).
- Decode (shared constants): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 1111111→blank (4'hF). Any other pattern is invalid.
- Per-digit filter FSM, states IDLE, TRACK, LOCKED; holds cand[3:0] and cnt ($clog2(STABLE_CNT+1) bits).
  - IDLE: valid sample → cand=code, cnt=1, go TRACK.
  - TRACK: valid sample with code==cand → cnt+1; on reaching STABLE_CNT, commit cand to output and go LOCKED. Valid sample with code!=cand → cand=code, cnt=1. Invalid sample → IDLE, cnt=0.
  - LOCKED: code==cand → stay (cnt saturates). Valid code!=cand → cand=code, cnt=1, TRACK; output holds last committed value. Invalid → IDLE; output holds.
- Commit: output register loads cand; oUPDATE pulses only if the new value differs from the old one. First commit sets that digit's "seen" flag; oVALID = seen1 & seen2.
- Counting is per digit: samples for the other digit and no-sample cycles neither advance nor break a digit's run.
- oERR_STICKY: set dominates clear when an error and iCLR_ERR coincide.

## Timing
- Reset values: oD1=oD2=4'hF, oVALID=0, oUPDATE=0, oERR=0, oERR_STICKY=0; FSMs in IDLE, cnt=0, seen flags 0.
- All outputs registered. Commit latency: oD*, oUPDATE and (if applicable) oVALID change at the edge that takes the STABLE_CNT-th matching sample. No combinational input→output path.
- oERR asserts at the edge sampling the bad pattern/collision, for exactly one cycle. oERR_STICKY is set at the same edge.
- Both digits committing on the same edge is impossible (one sample per cycle). A digit re-committing an unchanged value produces no oUPDATE.
- iRST asserted mid-run: all state clears immediately, regardless of clock; the first post-reset sample starts from IDLE.

## Structure
- Package seg7_pkg: the ten digit patterns and the blank pattern as 7-bit constants, BLANK_CODE = 4'hF, FSM state enum. The existing driver takes its patterns from the same package.
- Sub-module seg7_digit_filter (decode + FSM + counter + output register + seen flag), instantiated twice. The top level handles select qualification, the error logic, oUPDATE OR-ing and oVALID.

## Test plan
- Reset, then iDIG_SEL alternates 01/10 with patterns for 4 and 7, STABLE_CNT=8 → oD1=4, oD2=7 at the 8th sample of each. oVALID rises with the second commit, and one oUPDATE pulse per digit.
- Digit 1 stable at 3 for 5 samples, one sample of 8, then 3 again → no commit until 8 further consecutive samples of 3. A glitch after LOCKED leaves oD1 unchanged.
- iSEG=7'b1010101 on digit 2 → oERR pulse, oERR_STICKY=1, digit 2 FSM in IDLE. iCLR_ERR on the same cycle as a second error → oERR_STICKY stays 1.
- iDIG_SEL=2'b11 → oERR pulse, no counter changes. 2'b00 interleaved between samples → runs are not broken.
- Blank pattern 1111111 held on digit 1 after a committed 5 → oD1=4'hF after 8 samples, with an oUPDATE pulse.
- iRST asserted asynchronously while digit 2 is at cnt=6 → outputs return to reset values immediately, and a full 8-sample run is needed afterward.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low, bit0=a .. bit6=g) and decode helpers
// used by both the display driver and the scan decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } filt_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } seg_dec_t;

  function automatic seg_dec_t seg7_decode(input logic [6:0] seg);
    seg_dec_t d;
    d.valid = 1'b1;
    d.code  = 4'd0;
    case (seg)
      SEG_0:     d.code = 4'd0;
      SEG_1:     d.code = 4'd1;
      SEG_2:     d.code = 4'd2;
      SEG_3:     d.code = 4'd3;
      SEG_4:     d.code = 4'd4;
      SEG_5:     d.code = 4'd5;
      SEG_6:     d.code = 4'd6;
      SEG_7:     d.code = 4'd7;
      SEG_8:     d.code = 4'd8;
      SEG_9:     d.code = 4'd9;
      SEG_BLANK: d.code = BLANK_CODE;
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic seg7_is_valid(input logic [6:0] seg);
    seg_dec_t d;
    d = seg7_decode(seg);
    return d.valid;
  endfunction

endpackage

// File: rtl/seg7_digit_filter.sv
// One digit's glitch filter: decodes qualified samples and commits a code only after
// STABLE_CNT consecutive identical valid samples.
module seg7_digit_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_smp,
  input  logic [6:0] i_seg,
  output logic [3:0] o_dig,
  output logic       o_upd,
  output logic       o_seen
);

  localparam int             CW       = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(STABLE_CNT);

  seg_dec_t      w_dec;
  filt_state_e   r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_dig;
  logic          r_upd;
  logic          r_seen;

  assign w_dec = seg7_decode(i_seg);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cand  <= BLANK_CODE;
      r_cnt   <= '0;
      r_dig   <= BLANK_CODE;
      r_upd   <= 1'b0;
      r_seen  <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      // Cycles without a sample for this digit leave the run untouched.
      if (i_smp) begin
        if (!w_dec.valid) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_cand  <= w_dec.code;
              r_cnt   <= CNT_ONE;
              r_state <= ST_TRACK;
            end
            ST_TRACK: begin
              if (w_dec.code == r_cand) begin
                if (r_cnt == CNT_LAST) begin
                  r_cnt   <= CNT_FULL;
                  r_dig   <= r_cand;
                  r_upd   <= (r_cand != r_dig);
                  r_seen  <= 1'b1;
                  r_state <= ST_LOCKED;
                end else begin
                  r_cnt <= r_cnt + CNT_ONE;
                end
              end else begin
                r_cand <= w_dec.code;
                r_cnt  <= CNT_ONE;
              end
            end
            ST_LOCKED: begin
              if (w_dec.code != r_cand) begin
                r_cand  <= w_dec.code;
                r_cnt   <= CNT_ONE;
                r_state <= ST_TRACK;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign o_dig  = r_dig;
  assign o_upd  = r_upd;
  assign o_seen = r_seen;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the two-digit multiplexed seven-segment bus: qualifies samples by
// digit select, filters each digit, and flags bad patterns and select collisions.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 8
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [6:0] iSEG,
  input  logic [1:0] iDIG_SEL,
  input  logic       iCLR_ERR,
  output logic [3:0] oD1,
  output logic [3:0] oD2,
  output logic       oVALID,
  output logic       oUPDATE,
  output logic       oERR,
  output logic       oERR_STICKY
);

  logic w_smp1, w_smp2, w_coll, w_bad;
  logic w_upd1, w_upd2, w_seen1, w_seen2;
  logic r_err, r_sticky;

  assign w_smp1 = (iDIG_SEL == 2'b01);
  assign w_smp2 = (iDIG_SEL == 2'b10);
  assign w_coll = (iDIG_SEL == 2'b11);
  assign w_bad  = w_coll | ((w_smp1 | w_smp2) & ~seg7_is_valid(iSEG));

  seg7_digit_filter #(.STABLE_CNT(STABLE_CNT)) u_dig1 (
    .i_clk  (iCLK),
    .i_rst  (iRST),
    .i_smp  (w_smp1),
    .i_seg  (iSEG),
    .o_dig  (oD1),
    .o_upd  (w_upd1),
    .o_seen (w_seen1)
  );

  seg7_digit_filter #(.STABLE_CNT(STABLE_CNT)) u_dig2 (
    .i_clk  (iCLK),
    .i_rst  (iRST),
    .i_smp  (w_smp2),
    .i_seg  (iSEG),
    .o_dig  (oD2),
    .o_upd  (w_upd2),
    .o_seen (w_seen2)
  );

  // A new error wins over a coincident clear so no event is ever lost.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_err <= w_bad;
      if (w_bad)
        r_sticky <= 1'b1;
      else if (iCLR_ERR)
        r_sticky <= 1'b0;
    end
  end

  assign oERR        = r_err;
  assign oERR_STICKY = r_sticky;
  assign oUPDATE     = w_upd1 | w_upd2;
  assign oVALID      = w_seen1 & w_seen2;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed-step bench for seg7_scan_decoder: each step queues its expected outputs
// and checks them just after the sampling edge.
module tb_seg7_scan_decoder;

  localparam logic [6:0] P0  = 7'b1000000;
  localparam logic [6:0] P3  = 7'b0110000;
  localparam logic [6:0] P4  = 7'b0011001;
  localparam logic [6:0] P5  = 7'b0010010;
  localparam logic [6:0] P7  = 7'b1111000;
  localparam logic [6:0] P8  = 7'b0000000;
  localparam logic [6:0] PB  = 7'b1111111;
  localparam logic [6:0] BAD = 7'b1010101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] iSEG = PB;
  logic [1:0] iDIG_SEL = 2'b00;
  logic       iCLR_ERR = 1'b0;
  logic [3:0] oD1, oD2;
  logic       oVALID, oUPDATE, oERR, oERR_STICKY;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       v;
    logic       u;
    logic       e;
    logic       s;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_step = 0;
  logic [3:0] e_d1 = 4'hF;
  logic [3:0] e_d2 = 4'hF;
  logic       e_v  = 1'b0;
  logic       e_st = 1'b0;

  seg7_scan_decoder #(.STABLE_CNT(8)) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iSEG        (iSEG),
    .iDIG_SEL    (iDIG_SEL),
    .iCLR_ERR    (iCLR_ERR),
    .oD1         (oD1),
    .oD2         (oD2),
    .oVALID      (oVALID),
    .oUPDATE     (oUPDATE),
    .oERR        (oERR),
    .oERR_STICKY (oERR_STICKY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n_step, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] sel, input logic [6:0] seg, input logic clr,
                      input logic upd, input logic err);
    exp_t x;
    @(negedge clk);
    iDIG_SEL = sel;
    iSEG     = seg;
    iCLR_ERR = clr;
    if (err)      e_st = 1'b1;
    else if (clr) e_st = 1'b0;
    x = '{d1: e_d1, d2: e_d2, v: e_v, u: upd, e: err, s: e_st};
    q.push_back(x);
    @(posedge clk);
    #1;
    n_step++;
    x = q.pop_front();
    chk("d1",     oD1,                x.d1);
    chk("d2",     oD2,                x.d2);
    chk("valid",  {3'b0, oVALID},     {3'b0, x.v});
    chk("update", {3'b0, oUPDATE},    {3'b0, x.u});
    chk("err",    {3'b0, oERR},       {3'b0, x.e});
    chk("sticky", {3'b0, oERR_STICKY},{3'b0, x.s});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_d1"},     oD1,                 4'hF);
    chk({tag, "_d2"},     oD2,                 4'hF);
    chk({tag, "_valid"},  {3'b0, oVALID},      4'h0);
    chk({tag, "_update"}, {3'b0, oUPDATE},     4'h0);
    chk({tag, "_err"},    {3'b0, oERR},        4'h0);
    chk({tag, "_sticky"}, {3'b0, oERR_STICKY}, 4'h0);
  endtask

  initial begin
    #12;
    chk_reset_state("rst");
    @(negedge clk);
    rst = 1'b0;

    // Alternating 4 / 7: each digit commits on its 8th sample.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) e_d1 = 4'd4;
      step(2'b01, P4, 1'b0, i == 7, 1'b0);
      if (i == 7) begin e_d2 = 4'd7; e_v = 1'b1; end
      step(2'b10, P7, 1'b0, i == 7, 1'b0);
    end

    // Interrupted run of 3, then a clean run with idle (unsampled) cycles between.
    repeat (5) step(2'b01, P3, 1'b0, 1'b0, 1'b0);
    step(2'b01, P8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(2'b00, BAD, 1'b0, 1'b0, 1'b0);
      if (i == 7) e_d1 = 4'd3;
      step(2'b01, P3, 1'b0, i == 7, 1'b0);
    end
    step(2'b01, P8, 1'b0, 1'b0, 1'b0);
    step(2'b01, P3, 1'b0, 1'b0, 1'b0);

    // Invalid pattern on digit 2 restarts its run; clear loses to a coincident error.
    repeat (4) step(2'b10, P0, 1'b0, 1'b0, 1'b0);
    step(2'b10, BAD, 1'b0, 1'b0, 1'b1);
    step(2'b10, BAD, 1'b1, 1'b0, 1'b1);
    step(2'b00, P0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) e_d2 = 4'd0;
      step(2'b10, P0, 1'b0, i == 7, 1'b0);
    end

    // Collision in the middle of a digit-1 run neither counts nor breaks it.
    repeat (4) step(2'b01, P5, 1'b0, 1'b0, 1'b0);
    step(2'b11, P5, 1'b0, 1'b0, 1'b1);
    repeat (3) step(2'b01, P5, 1'b0, 1'b0, 1'b0);
    e_d1 = 4'd5;
    step(2'b01, P5, 1'b0, 1'b1, 1'b0);
    step(2'b00, P5, 1'b1, 1'b0, 1'b0);

    // Blank commits like any other code.
    repeat (7) step(2'b01, PB, 1'b0, 1'b0, 1'b0);
    e_d1 = 4'hF;
    step(2'b01, PB, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while digit 2 is six samples into a run.
    repeat (3) step(2'b10, P8, 1'b0, 1'b0, 1'b0);
    step(2'b11, P8, 1'b0, 1'b0, 1'b1);
    repeat (3) step(2'b10, P8, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    iDIG_SEL = 2'b00;
    #1;
    chk_reset_state("async_rst");
    @(negedge clk);
    rst  = 1'b0;
    e_d1 = 4'hF;
    e_d2 = 4'hF;
    e_v  = 1'b0;
    e_st = 1'b0;
    repeat (7) step(2'b10, P8, 1'b0, 1'b0, 1'b0);
    e_d2 = 4'd8;
    step(2'b10, P8, 1'b0, 1'b1, 1'b0);
    step(2'b00, P8, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
